// File: rtl/rs_int.sv
// Integer reservation station: holds renamed uops until operands arrive,
// snoops EX1 write-back for wakeup/capture, and issues the oldest ready uop.
package rs_int_pkg;
   typedef logic [5:0]  t_prf_id;
   typedef logic [5:0]  t_rob_id;
   typedef logic [31:0] t_rv_reg_data;

   typedef enum logic [1:0] {
      OP_REG  = 2'd0,
      OP_IMM  = 2'd1,
      OP_ZERO = 2'd2,
      OP_PC   = 2'd3
   } t_optype;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      t_optype     src1_optype;
      t_optype     src2_optype;
      logic [11:0] imm;
   } t_uinstr;

   typedef struct packed {
      logic valid;
   } t_nuke_pkt;

   typedef struct packed {
      t_prf_id      pdst;
      t_rv_reg_data data;
   } t_prf_wr_pkt;

   typedef struct packed {
      t_uinstr      uinstr;
      t_rob_id      robid;
      t_prf_id      pdst;
      t_rv_reg_data src1_val;
      t_rv_reg_data src2_val;
   } t_uinstr_iss;
endpackage

module rs_int
   import rs_int_pkg::*;
#(
   parameter int NUM_ENTRIES = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  t_nuke_pkt    nuke_rb1,
   input  logic         disp_valid_rs0,
   output logic         disp_rdy_rs0,
   input  t_uinstr      disp_uinstr_rs0,
   input  t_rob_id      disp_robid_rs0,
   input  t_prf_id      disp_pdst_rs0,
   input  t_prf_id      disp_psrc1_rs0,
   input  t_prf_id      disp_psrc2_rs0,
   input  logic         disp_src1_rdy_rs0,
   input  logic         disp_src2_rdy_rs0,
   input  t_rv_reg_data disp_src1_val_rs0,
   input  t_rv_reg_data disp_src2_val_rs0,
   input  logic         iprf_wr_en_ex1,
   input  t_prf_wr_pkt  iprf_wr_pkt_ex1,
   output logic         iss_ex0,
   output t_uinstr_iss  iss_pkt_ex0
);
   localparam int IW = $clog2(NUM_ENTRIES);
   localparam int OW = IW + 1;

   logic [NUM_ENTRIES-1:0] valid_q, valid_d;
   logic [NUM_ENTRIES-1:0] s1_rdy_q, s1_rdy_d;
   logic [NUM_ENTRIES-1:0] s2_rdy_q, s2_rdy_d;
   logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] age_d [NUM_ENTRIES];
   logic [OW-1:0]          occ_q, occ_d;
   logic                   iss_vld_q, iss_vld_d;
   t_uinstr_iss            iss_pkt_q, iss_pkt_d;

   t_prf_id      psrc1_q [NUM_ENTRIES];
   t_prf_id      psrc1_d [NUM_ENTRIES];
   t_prf_id      psrc2_q [NUM_ENTRIES];
   t_prf_id      psrc2_d [NUM_ENTRIES];
   t_rv_reg_data s1_val_q [NUM_ENTRIES];
   t_rv_reg_data s1_val_d [NUM_ENTRIES];
   t_rv_reg_data s2_val_q [NUM_ENTRIES];
   t_rv_reg_data s2_val_d [NUM_ENTRIES];
   t_uinstr      uinstr_q [NUM_ENTRIES];
   t_uinstr      uinstr_d [NUM_ENTRIES];
   t_rob_id      robid_q [NUM_ENTRIES];
   t_rob_id      robid_d [NUM_ENTRIES];
   t_prf_id      pdst_q [NUM_ENTRIES];
   t_prf_id      pdst_d [NUM_ENTRIES];

   logic                   alloc;
   logic [IW-1:0]          alloc_idx;
   logic [NUM_ENTRIES-1:0] elig;
   logic [NUM_ENTRIES-1:0] sel;
   logic                   sel_any;
   logic                   d_s1_rdy, d_s2_rdy;
   t_rv_reg_data           d_s1_val, d_s2_val;

   always_comb begin : p_alloc
      logic found;
      found        = 1'b0;
      alloc_idx    = '0;
      disp_rdy_rs0 = (occ_q < OW'(NUM_ENTRIES));
      alloc        = disp_valid_rs0 & disp_rdy_rs0 & ~nuke_rb1.valid;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!valid_q[i] && !found) begin
            alloc_idx = IW'(i);
            found     = 1'b1;
         end
      end
   end

   // Non-register operands are zeroed here; EX muxes in the immediate itself.
   always_comb begin : p_disp_src
      logic s1_reg, s2_reg, s1_byp, s2_byp;
      s1_reg   = (disp_uinstr_rs0.src1_optype == OP_REG);
      s2_reg   = (disp_uinstr_rs0.src2_optype == OP_REG);
      s1_byp   = iprf_wr_en_ex1 && (iprf_wr_pkt_ex1.pdst == disp_psrc1_rs0);
      s2_byp   = iprf_wr_en_ex1 && (iprf_wr_pkt_ex1.pdst == disp_psrc2_rs0);
      d_s1_rdy = !s1_reg || disp_src1_rdy_rs0 || s1_byp;
      d_s2_rdy = !s2_reg || disp_src2_rdy_rs0 || s2_byp;
      d_s1_val = !s1_reg ? '0 : (disp_src1_rdy_rs0 ? disp_src1_val_rs0 : iprf_wr_pkt_ex1.data);
      d_s2_val = !s2_reg ? '0 : (disp_src2_rdy_rs0 ? disp_src2_val_rs0 : iprf_wr_pkt_ex1.data);
   end

   always_comb begin : p_select
      logic blk;
      elig = valid_q & s1_rdy_q & s2_rdy_q;
      sel  = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         blk = 1'b0;
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (j != i && elig[j] && age_q[j][i]) blk = 1'b1;
         end
         sel[i] = elig[i] & ~blk;
      end
      sel_any = |sel;
   end

   always_comb begin : p_next
      valid_d   = valid_q;
      s1_rdy_d  = s1_rdy_q;
      s2_rdy_d  = s2_rdy_q;
      age_d     = age_q;
      psrc1_d   = psrc1_q;
      psrc2_d   = psrc2_q;
      s1_val_d  = s1_val_q;
      s2_val_d  = s2_val_q;
      uinstr_d  = uinstr_q;
      robid_d   = robid_q;
      pdst_d    = pdst_q;
      iss_pkt_d = iss_pkt_q;
      iss_vld_d = sel_any;
      occ_d     = occ_q + OW'(alloc) - OW'(sel_any);

      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (valid_q[i] && iprf_wr_en_ex1) begin
            if (!s1_rdy_q[i] && psrc1_q[i] == iprf_wr_pkt_ex1.pdst) begin
               s1_rdy_d[i] = 1'b1;
               s1_val_d[i] = iprf_wr_pkt_ex1.data;
            end
            if (!s2_rdy_q[i] && psrc2_q[i] == iprf_wr_pkt_ex1.pdst) begin
               s2_rdy_d[i] = 1'b1;
               s2_val_d[i] = iprf_wr_pkt_ex1.data;
            end
         end
         if (sel[i]) begin
            valid_d[i]         = 1'b0;
            iss_pkt_d.uinstr   = uinstr_q[i];
            iss_pkt_d.robid    = robid_q[i];
            iss_pkt_d.pdst     = pdst_q[i];
            iss_pkt_d.src1_val = s1_val_q[i];
            iss_pkt_d.src2_val = s2_val_q[i];
         end
      end

      // New entry is younger than everything currently valid.
      if (alloc) begin
         valid_d[alloc_idx]  = 1'b1;
         s1_rdy_d[alloc_idx] = d_s1_rdy;
         s2_rdy_d[alloc_idx] = d_s2_rdy;
         s1_val_d[alloc_idx] = d_s1_val;
         s2_val_d[alloc_idx] = d_s2_val;
         psrc1_d[alloc_idx]  = disp_psrc1_rs0;
         psrc2_d[alloc_idx]  = disp_psrc2_rs0;
         uinstr_d[alloc_idx] = disp_uinstr_rs0;
         robid_d[alloc_idx]  = disp_robid_rs0;
         pdst_d[alloc_idx]   = disp_pdst_rs0;
         age_d[alloc_idx]    = '0;
         for (int j = 0; j < NUM_ENTRIES; j++) age_d[j][alloc_idx] = valid_q[j];
      end

      if (nuke_rb1.valid) begin
         valid_d   = '0;
         occ_d     = '0;
         iss_vld_d = 1'b0;
         for (int i = 0; i < NUM_ENTRIES; i++) age_d[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= '0;
         s1_rdy_q  <= '0;
         s2_rdy_q  <= '0;
         occ_q     <= '0;
         iss_vld_q <= 1'b0;
         iss_pkt_q <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= '0;
      end else begin
         valid_q   <= valid_d;
         s1_rdy_q  <= s1_rdy_d;
         s2_rdy_q  <= s2_rdy_d;
         occ_q     <= occ_d;
         iss_vld_q <= iss_vld_d;
         iss_pkt_q <= iss_pkt_d;
         age_q     <= age_d;
      end
   end

   always_ff @(posedge clk) begin
      psrc1_q  <= psrc1_d;
      psrc2_q  <= psrc2_d;
      s1_val_q <= s1_val_d;
      s2_val_q <= s2_val_d;
      uinstr_q <= uinstr_d;
      robid_q  <= robid_d;
      pdst_q   <= pdst_d;
   end

   assign iss_ex0     = iss_vld_q;
   assign iss_pkt_ex0 = iss_pkt_q;

`ifndef SYNTHESIS
   a_one_sel:   assert property (@(posedge clk) disable iff (reset) $onehot0(sel));
   a_alloc_free: assert property (@(posedge clk) disable iff (reset) alloc |-> !valid_q[alloc_idx]);
   a_occ_cnt:   assert property (@(posedge clk) disable iff (reset) occ_q == OW'($countones(valid_q)));
   a_sel_rdy:   assert property (@(posedge clk) disable iff (reset) (sel & ~elig) == '0);
`endif
endmodule
